// File: rtl/nios_debug_scan_master.sv
// nios_debug_scan_master
// ----------------------
// Initiator for the Nios II virtual-JTAG debug scan interface. One command
// (instruction + data word) produces the strobe sequence
//    [UIR] -> CDR -> SDR x DR_WIDTH -> UDR -> RTI
// together with a divided test clock. The data word goes out on vji_tdi
// LSB first and vji_tdo is captured LSB first into the response word.
// UIR is skipped when the requested instruction is already loaded.
//
// Ports
//    clk, reset           system clock, synchronous active-high reset
//    cmd_valid/cmd_ready  command handshake; cmd_ir / cmd_dr are the payload
//    rsp_valid/rsp_ready  response handshake; rsp_dr holds the tdo bits
//    busy                 high whenever the engine is not idle
//    vji_tck/tdi/tdo      generated test clock and serial data
//    vji_ir_in            instruction currently presented to the slave
//    vji_uir..vji_rti     one-hot virtual-state strobes
//
// Every state of the scan lasts a whole number of tck periods. Each period
// is 2*TCK_DIV clk cycles: tck low for the first half, high for the second.

module nios_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                busy,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int PERIOD = 2 * TCK_DIV;
   localparam int CW     = $clog2(PERIOD);
   localparam int BW     = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

   // Phase on which the next cycle shows tck high (the rising edge), and the
   // last phase of a period.
   localparam logic [CW-1:0] RISE_AT  = CW'(TCK_DIV - 1);
   localparam logic [CW-1:0] LAST_AT  = CW'(PERIOD - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UIR,
      S_CDR,
      S_SDR,
      S_UDR,
      S_RTI,
      S_RESP
   } state_t;

   state_t                state_reg;
   logic [CW-1:0]         phase_reg;
   logic [BW-1:0]         bit_reg;
   logic [DR_WIDTH-1:0]   dr_reg;
   logic [DR_WIDTH-1:0]   cap_next;

   // tdo enters at the MSB and walks down, so after DR_WIDTH captures the
   // first sampled bit sits at bit 0.
   generate
      if (DR_WIDTH == 1) begin : g_cap_one
         assign cap_next = vji_tdo;
      end else begin : g_cap_many
         assign cap_next = {vji_tdo, rsp_dr[DR_WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         phase_reg <= '0;
         bit_reg   <= '0;
         dr_reg    <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_dr    <= '0;
         busy      <= 1'b0;
         vji_tck   <= 1'b0;
         vji_tdi   <= 1'b0;
         vji_ir_in <= '0;
         vji_uir   <= 1'b0;
         vji_cdr   <= 1'b0;
         vji_sdr   <= 1'b0;
         vji_udr   <= 1'b0;
         vji_rti   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  dr_reg    <= cmd_dr;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  phase_reg <= '0;
                  vji_tck   <= 1'b0;
                  // The instruction register only needs an update scan when
                  // it actually changes.
                  if (cmd_ir != vji_ir_in) begin
                     vji_ir_in <= cmd_ir;
                     vji_uir   <= 1'b1;
                     state_reg <= S_UIR;
                  end else begin
                     vji_cdr   <= 1'b1;
                     state_reg <= S_CDR;
                  end
               end
            end

            S_RESP: begin
               // Response word is frozen here; new commands wait for IDLE.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end

            default: begin
               // Scan states share the tck divider.
               if (phase_reg == RISE_AT) begin
                  vji_tck <= 1'b1;
                  if (state_reg == S_SDR) begin
                     rsp_dr <= cap_next;
                  end
               end

               if (phase_reg == LAST_AT) begin
                  phase_reg <= '0;
                  vji_tck   <= 1'b0;
                  case (state_reg)
                     S_UIR: begin
                        vji_uir   <= 1'b0;
                        vji_cdr   <= 1'b1;
                        state_reg <= S_CDR;
                     end
                     S_CDR: begin
                        vji_cdr   <= 1'b0;
                        vji_sdr   <= 1'b1;
                        vji_tdi   <= dr_reg[0];
                        dr_reg    <= dr_reg >> 1;
                        bit_reg   <= '0;
                        state_reg <= S_SDR;
                     end
                     S_SDR: begin
                        if (bit_reg == LAST_BIT) begin
                           vji_sdr   <= 1'b0;
                           vji_tdi   <= 1'b0;
                           vji_udr   <= 1'b1;
                           state_reg <= S_UDR;
                        end else begin
                           bit_reg <= bit_reg + BW'(1);
                           vji_tdi <= dr_reg[0];
                           dr_reg  <= dr_reg >> 1;
                        end
                     end
                     S_UDR: begin
                        vji_udr   <= 1'b0;
                        vji_rti   <= 1'b1;
                        state_reg <= S_RTI;
                     end
                     default: begin
                        vji_rti   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= S_RESP;
                     end
                  endcase
               end else begin
                  phase_reg <= phase_reg + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: doc/nios_debug_scan_master.md
Name: nios_debug_scan_master

Overview:
- Initiator side of the Nios II virtual-JTAG debug scan interface.
- Takes one command: a 2-bit instruction plus a DR_WIDTH-bit data word.
- Generates the tck/tdi and virtual-state strobe sequence (UIR, CDR, SDR, UDR, RTI) that a debug slave's TCK-domain logic expects.
- Captures tdo into a response word.
- Lets on-chip test logic and simulation benches drive the debug slave without a physical JTAG hub.

Parameters:
- DR_WIDTH, 38, length of the data scan in bits (>=1).
- IR_WIDTH, 2, instruction width.
- TCK_DIV, 2, clk cycles per tck half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_ir  in  IR_WIDTH  instruction for this scan.
- cmd_dr  in  DR_WIDTH  data shifted out on tdi, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_dr  out  DR_WIDTH  tdo bits captured, LSB first.
- busy  out  1  high in any state other than IDLE.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to the slave.
- vji_tdo  in  1  serial data from the slave.
- vji_ir_in  out  IR_WIDTH  current instruction.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, busy=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes=0.
- Reset asserted mid-operation:
  - Every output returns to its reset value on the same edge.
  - The partial scan is discarded; no rsp_valid is produced.
  - The stored IR becomes 0.
- TCK period = 2*TCK_DIV clk cycles: tck low for the first TCK_DIV cycles, high for the last TCK_DIV. Each non-IDLE/RESP state lasts a whole number of periods, and every period starts with tck low.
- States:
  - IDLE: cmd_ready=1. On acceptance (edge 0), latch cmd_ir/cmd_dr. Go to UIR if cmd_ir != vji_ir_in, else go directly to CDR.
  - UIR: one period. vji_uir=1 and vji_ir_in=latched ir for the whole period; vji_ir_in holds that value until a later UIR or reset.
  - CDR: one period, vji_cdr=1.
  - SDR: DR_WIDTH periods, vji_sdr=1 throughout.
    - In period i, vji_tdi = cmd_dr[i] from the period's first cycle.
    - vji_tdo is sampled on the clk edge where tck rises and stored as rsp_dr[i].
  - UDR: one period, vji_udr=1.
  - RTI: one period, vji_rti=1.
  - RESP: rsp_valid=1, held until rsp_ready; rsp_dr stable while rsp_valid is high. On handshake go to IDLE; cmd_ready returns to 1 on the next cycle.
- Outside SDR, vji_tdi=0. Exactly one strobe is high in each scan state; none is high in IDLE or RESP.
- cmd_ready is 0 in every state except IDLE, so a new command cannot overlap an unconsumed response.
- Latency:
  - With UIR: P = (DR_WIDTH+4) periods, so the scan occupies cycles 1..P*2*TCK_DIV and rsp_valid is first high at cycle P*2*TCK_DIV+1.
  - Without UIR: P = DR_WIDTH+3.
  - Defaults: 169 cycles with UIR, 165 without.
- Simultaneous rsp_ready and cmd_valid in RESP: the response is consumed; the command waits for IDLE.
- cmd inputs are ignored outside IDLE.

Test Plan:
1. Reset, then idle 5 cycles -> cmd_ready=1, tck=0, all strobes 0, vji_ir_in=0, rsp_valid=0.
2. Slave model: a 38-bit shift register preloaded with 0x2A_5A5A_5A5A at CDR, shifting on tck rise. Send ir=2'b01, dr=0x15_A5A5_A5A5 -> uir pulse, vji_ir_in=01, 38 tdi bits LSB first match, rsp_dr=0x2A_5A5A_5A5A, rsp_valid first high at cycle 169.
3. Second command with ir=2'b01 -> no uir pulse; rsp_valid at cycle 165. Third command with ir=2'b10 -> uir pulse present, 169 cycles.
4. Hold rsp_ready=0 for 10 cycles after rsp_valid while cmd_valid=1 -> rsp_valid and rsp_dr held stable, cmd_ready=0. Release -> cmd_ready=1 on the following cycle, then the command is accepted.
5. Assert reset during SDR bit 17 -> on that edge all strobes, tck and tdi are 0, cmd_ready=1, vji_ir_in=0; rsp_valid never asserts.
6. TCK_DIV=1, DR_WIDTH=4: tdi alternating 1010, tdo tied to 1 -> tck toggles every cycle, rsp_dr=4'hF, rsp_valid at cycle 17.
